// File: rtl/radar_pack_pkg.sv
// Shared definitions for the radar Rx packer: FSM encoding, framing constants and helpers.
// Trailer length depends on RADAR_PACK_DROPCNT_EN.
package radar_pack_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR0   = 3'd1,
        ST_HDR1   = 3'd2,
        ST_DATA_I = 3'd3,
        ST_DATA_Q = 3'd4,
        ST_TRL    = 3'd5
    } state_e;

    localparam logic [15:0] SYNC_WORD_DEF = 16'hA5A5;
    localparam int          HDR_WORDS     = 2;
`ifdef RADAR_PACK_DROPCNT_EN
    localparam int          TRL_WORDS     = 2;
`else
    localparam int          TRL_WORDS     = 1;
`endif

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/radar_pair_fifo.sv
// Pair buffer between the echo strobe and the framing FSM: AW+1 bit pointers with a wrap bit,
// synchronous write, combinational head read.
module radar_pair_fifo #(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    output logic [DW-1:0] dout_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          do_push, do_pop;

    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/radar_rx_packer.sv
// Frames echo I/Q pairs into 16-bit Rx FIFO words: sync, pulse number, I/Q pairs, trailer.
// Define RADAR_PACK_DROPCNT_EN to append a saturating drop count after the pair count.
module radar_rx_packer
    import radar_pack_pkg::*;
#(
    parameter int          AW        = 4,
    parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEF
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        ena_i,
    input  logic [15:0] pulse_num_i,
    input  logic        rx_strobe_i,
    input  logic [15:0] rx_i_i,
    input  logic [15:0] rx_q_i,
    input  logic        fifo_full_i,
    output logic        fifo_we_o,
    output logic [15:0] fifo_data_o,
    output logic        overrun_o,
    output logic        busy_o
);

    state_e      state_q, state_d;
    logic        ena_d_q;
    logic        open_q, open_d;
    logic [15:0] pnum_q, pnum_d;
    logic [15:0] cnt_q, cnt_d;
    logic        overrun_q, overrun_d;
    logic        fifo_we_q, fifo_we_d;
    logic [15:0] fifo_data_q, fifo_data_d;
`ifdef RADAR_PACK_DROPCNT_EN
    logic [15:0] dropcnt_q, dropcnt_d;
    logic        trl_sel_q, trl_sel_d;
`endif

    logic        rise, fall, start, skip, accept, push, drop, pop;
    logic        buf_full, buf_empty;
    logic [31:0] buf_head;

    assign rise   = ena_i & ~ena_d_q;
    assign fall   = ~ena_i & ena_d_q;
    assign start  = rise & (state_q == ST_IDLE);
    assign skip   = rise & (state_q != ST_IDLE);
    // The rise cycle itself already belongs to the new record.
    assign accept = rx_strobe_i & ena_i & (open_q | start);
    assign push   = accept & ~buf_full;
    assign drop   = accept & buf_full;

    radar_pair_fifo #(.AW(AW), .DW(32)) u_pair_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (push),
        .din_i   ({rx_i_i, rx_q_i}),
        .pop_i   (pop),
        .dout_o  (buf_head),
        .full_o  (buf_full),
        .empty_o (buf_empty)
    );

    always_comb begin
        open_d    = open_q;
        pnum_d    = pnum_q;
        cnt_d     = cnt_q;
        overrun_d = overrun_q | drop | skip;
        if (start) begin
            open_d = 1'b1;
            pnum_d = pulse_num_i;
        end else if (fall) begin
            open_d = 1'b0;
        end
        if (start)     cnt_d = push ? 16'd1 : 16'd0;
        else if (push) cnt_d = sat_inc16(cnt_q);
    end

`ifdef RADAR_PACK_DROPCNT_EN
    always_comb begin
        dropcnt_d = dropcnt_q;
        if (start)     dropcnt_d = drop ? 16'd1 : 16'd0;
        else if (drop) dropcnt_d = sat_inc16(dropcnt_q);
    end
`endif

    always_comb begin
        state_d     = state_q;
        fifo_we_d   = 1'b0;
        fifo_data_d = fifo_data_q;
        pop         = 1'b0;
`ifdef RADAR_PACK_DROPCNT_EN
        trl_sel_d   = trl_sel_q;
`endif
        case (state_q)
            ST_IDLE: if (start) state_d = ST_HDR0;
            ST_HDR0: if (!fifo_full_i) begin
                fifo_we_d   = 1'b1;
                fifo_data_d = SYNC_WORD;
                state_d     = ST_HDR1;
            end
            ST_HDR1: if (!fifo_full_i) begin
                fifo_we_d   = 1'b1;
                fifo_data_d = pnum_q;
                state_d     = ST_DATA_I;
            end
            ST_DATA_I: begin
                if (!buf_empty) begin
                    if (!fifo_full_i) begin
                        fifo_we_d   = 1'b1;
                        fifo_data_d = buf_head[31:16];
                        state_d     = ST_DATA_Q;
                    end
                end else if (!open_q) begin
                    state_d = ST_TRL;
                end
            end
            ST_DATA_Q: if (!fifo_full_i) begin
                fifo_we_d   = 1'b1;
                fifo_data_d = buf_head[15:0];
                pop         = 1'b1;
                state_d     = ST_DATA_I;
            end
            ST_TRL: if (!fifo_full_i) begin
                fifo_we_d = 1'b1;
`ifdef RADAR_PACK_DROPCNT_EN
                if (!trl_sel_q) begin
                    fifo_data_d = cnt_q;
                    trl_sel_d   = 1'b1;
                end else begin
                    fifo_data_d = dropcnt_q;
                    trl_sel_d   = 1'b0;
                    state_d     = ST_IDLE;
                end
`else
                fifo_data_d = cnt_q;
                state_d     = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            ena_d_q     <= 1'b0;
            open_q      <= 1'b0;
            pnum_q      <= '0;
            cnt_q       <= '0;
            overrun_q   <= 1'b0;
            fifo_we_q   <= 1'b0;
            fifo_data_q <= '0;
`ifdef RADAR_PACK_DROPCNT_EN
            dropcnt_q   <= '0;
            trl_sel_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ena_d_q     <= ena_i;
            open_q      <= open_d;
            pnum_q      <= pnum_d;
            cnt_q       <= cnt_d;
            overrun_q   <= overrun_d;
            fifo_we_q   <= fifo_we_d;
            fifo_data_q <= fifo_data_d;
`ifdef RADAR_PACK_DROPCNT_EN
            dropcnt_q   <= dropcnt_d;
            trl_sel_q   <= trl_sel_d;
`endif
        end
    end

    assign fifo_we_o   = fifo_we_q;
    assign fifo_data_o = fifo_data_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_radar_rx_packer.sv
// Scoreboard bench for radar_rx_packer: directed records plus a long randomised back-pressure run.
module tb_radar_rx_packer;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        ena_i = 1'b0;
    logic [15:0] pulse_num_i = '0;
    logic        rx_strobe_i = 1'b0;
    logic [15:0] rx_i_i = '0;
    logic [15:0] rx_q_i = '0;
    logic        fifo_full_i = 1'b0;
    logic        fifo_we_o;
    logic [15:0] fifo_data_o;
    logic        overrun_o;
    logic        busy_o;

    logic [15:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic        rand_full = 1'b0;
    logic        full_prev = 1'b0;

    radar_rx_packer #(.AW(4), .SYNC_WORD(16'hA5A5)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .ena_i       (ena_i),
        .pulse_num_i (pulse_num_i),
        .rx_strobe_i (rx_strobe_i),
        .rx_i_i      (rx_i_i),
        .rx_q_i      (rx_q_i),
        .fifo_full_i (fifo_full_i),
        .fifo_we_o   (fifo_we_o),
        .fifo_data_o (fifo_data_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Monitor: every emitted word is popped from the expected stream.
    always @(negedge clk_i) begin
        if (rst_n_i && fifo_we_o) begin
            n_checks++;
            if (full_prev) begin
                n_fail++;
                $display("FAIL we_after_full: fifo_we_o=1 but fifo_full_i was 1 in the deciding cycle");
            end
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_word: got %h, required none", fifo_data_o);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (fifo_data_o !== e) begin
                    n_fail++;
                    $display("FAIL stream_word: got %h, required %h", fifo_data_o, e);
                end
            end
        end
        full_prev = fifo_full_i;
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        if (rand_full) fifo_full_i = ($urandom_range(0, 1) == 1);
    endtask

    task automatic cyc(input logic ena, input logic stb, input logic [15:0] i, input logic [15:0] q);
        ena_i = ena; rx_strobe_i = stb; rx_i_i = i; rx_q_i = q;
        tick();
    endtask

    task automatic push_hdr(input logic [15:0] pnum);
        exp_q.push_back(16'hA5A5);
        exp_q.push_back(pnum);
    endtask

    task automatic push_pair(input logic [15:0] i, input logic [15:0] q);
        exp_q.push_back(i);
        exp_q.push_back(q);
    endtask

    task automatic push_trl(input logic [15:0] cnt, input logic [15:0] dcnt);
        exp_q.push_back(cnt);
`ifdef RADAR_PACK_DROPCNT_EN
        exp_q.push_back(dcnt);
`else
        if (dcnt != 16'hFFFF) exp_q.push_back(16'hFFFF);
        void'(exp_q.pop_back());
`endif
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_o && n < 3000) begin
            tick();
            n++;
        end
        if (busy_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: busy_o still 1 after %0d cycles, required 0", n);
        end
        tick();
        tick();
    endtask

    initial begin
        int found;

        // Reset state
        repeat (3) tick();
        check("rst_we", {15'd0, fifo_we_o}, 16'd0);
        check("rst_data", fifo_data_o, 16'h0000);
        check("rst_overrun", {15'd0, overrun_o}, 16'd0);
        check("rst_busy", {15'd0, busy_o}, 16'd0);
        rst_n_i = 1'b1;
        tick();

        // Basic 3-pair record
        pulse_num_i = 16'd7;
        push_hdr(16'h0007);
        push_pair(16'h0001, 16'hFFFF);
        push_pair(16'h0002, 16'hFFFE);
        push_pair(16'h0003, 16'hFFFD);
        push_trl(16'h0003, 16'h0000);
        cyc(1, 1, 16'h0001, 16'hFFFF);
        cyc(1, 1, 16'h0002, 16'hFFFE);
        cyc(1, 1, 16'h0003, 16'hFFFD);
        cyc(0, 0, 16'h0000, 16'h0000);
        wait_idle();
        check("t1_drained", 16'(exp_q.size()), 16'd0);
        check("t1_overrun", {15'd0, overrun_o}, 16'd0);

        // One-cycle window, strobe on the rise cycle
        pulse_num_i = 16'h1234;
        push_hdr(16'h1234);
        push_pair(16'hBEEF, 16'h8001);
        push_trl(16'h0001, 16'h0000);
        cyc(1, 1, 16'hBEEF, 16'h8001);
        cyc(0, 0, 16'h0000, 16'h0000);
        wait_idle();
        check("t4_drained", 16'(exp_q.size()), 16'd0);
        check("t4_overrun", {15'd0, overrun_o}, 16'd0);

        // Second rise while the first record is still pending
        fifo_full_i = 1'b1;
        pulse_num_i = 16'h0033;
        push_hdr(16'h0033);
        for (int k = 0; k < 3; k++) begin
            push_pair(16'h0300 + 16'(k), 16'h0310 + 16'(k));
            cyc(1, 1, 16'h0300 + 16'(k), 16'h0310 + 16'(k));
        end
        push_trl(16'h0003, 16'h0000);
        cyc(0, 0, 16'h0000, 16'h0000);
        pulse_num_i = 16'h0044;
        cyc(1, 1, 16'h0400, 16'h0410);
        cyc(1, 1, 16'h0401, 16'h0411);
        cyc(0, 0, 16'h0000, 16'h0000);
        repeat (4) tick();
        fifo_full_i = 1'b0;
        wait_idle();
        repeat (10) tick();
        check("t3_drained", 16'(exp_q.size()), 16'd0);
        check("t3_overrun", {15'd0, overrun_o}, 16'd1);
        check("t3_busy", {15'd0, busy_o}, 16'd0);

        // Asynchronous reset in the middle of a pair
        pulse_num_i = 16'h0055;
        rand_full = 1'b1;
        push_hdr(16'h0055);
        for (int k = 0; k < 4; k++) begin
            push_pair(16'h0011 + 16'(k), 16'h0F00 + 16'(k));
            cyc(1, 1, 16'h0011 + 16'(k), 16'h0F00 + 16'(k));
        end
        cyc(0, 0, 16'h0000, 16'h0000);
        found = 0;
        for (int n = 0; n < 200 && found == 0; n++) begin
            if (fifo_we_o && fifo_data_o == 16'h0011) found = 1;
            else tick();
        end
        if (found == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL t5_wait: first I word 0011 not seen, required within 200 cycles");
        end
        #2;
        rst_n_i = 1'b0;
        #1;
        check("t5_rst_we", {15'd0, fifo_we_o}, 16'd0);
        check("t5_rst_data", fifo_data_o, 16'h0000);
        check("t5_rst_overrun", {15'd0, overrun_o}, 16'd0);
        check("t5_rst_busy", {15'd0, busy_o}, 16'd0);
        exp_q.delete();
        rand_full = 1'b0;
        fifo_full_i = 1'b0;
        tick();
        tick();
        rst_n_i = 1'b1;
        tick();
        pulse_num_i = 16'h0066;
        push_hdr(16'h0066);
        push_pair(16'h7FFF, 16'h8000);
        push_pair(16'h0042, 16'h0024);
        push_trl(16'h0002, 16'h0000);
        cyc(1, 1, 16'h7FFF, 16'h8000);
        cyc(1, 0, 16'h0000, 16'h0000);
        cyc(1, 1, 16'h0042, 16'h0024);
        cyc(0, 0, 16'h0000, 16'h0000);
        wait_idle();
        check("t5_drained", 16'(exp_q.size()), 16'd0);

        // Back-pressure overflow: 20 strobes into a 16-pair buffer
        fifo_full_i = 1'b1;
        pulse_num_i = 16'h0200;
        push_hdr(16'h0200);
        for (int k = 0; k < 20; k++) begin
            if (k < 16) push_pair(16'h0100 + 16'(k), 16'h0200 + 16'(k));
            cyc(1, 1, 16'h0100 + 16'(k), 16'h0200 + 16'(k));
        end
        push_trl(16'h0010, 16'h0004);
        cyc(0, 0, 16'h0000, 16'h0000);
        repeat (19) tick();
        fifo_full_i = 1'b0;
        wait_idle();
        check("t2_drained", 16'(exp_q.size()), 16'd0);
        check("t2_overrun", {15'd0, overrun_o}, 16'd1);

        // Random back-pressure over many pulses
        rst_n_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
        tick();
        check("t6_overrun_cleared", {15'd0, overrun_o}, 16'd0);
        rand_full = 1'b1;
        for (int p = 0; p < 1000; p++) begin
            int npairs;
            npairs = $urandom_range(0, 3);
            pulse_num_i = 16'($urandom);
            push_hdr(pulse_num_i);
            for (int k = 0; k <= npairs; k++) begin
                if (k < npairs) begin
                    logic [15:0] vi, vq;
                    vi = 16'($urandom);
                    vq = 16'($urandom);
                    push_pair(vi, vq);
                    cyc(1, 1, vi, vq);
                end else begin
                    cyc(1, 0, 16'h0000, 16'h0000);
                end
            end
            push_trl(16'(npairs), 16'h0000);
            cyc(0, 0, 16'h0000, 16'h0000);
            wait_idle();
        end
        rand_full = 1'b0;
        fifo_full_i = 1'b0;
        repeat (4) tick();
        check("t6_drained", 16'(exp_q.size()), 16'd0);
        check("t6_overrun", {15'd0, overrun_o}, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
